// File: rtl/syscall_reader.sv
// syscall_reader: input-side syscall unit. Consumes a byte stream over a
// valid/ready handshake and assembles a signed or unsigned decimal integer,
// or a packed string of 4/8/12/16 characters, into rd0..rd3.
module syscall_reader #(
    parameter int         SYSCALL_ID = 26,
    parameter logic [7:0] TERM       = 8'h0A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ID,
    input  logic [31:0] rs,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INT_SIGN   = 3'd1;
    localparam logic [2:0] S_INT_DIGITS = 3'd2;
    localparam logic [2:0] S_STR        = 3'd3;
    localparam logic [2:0] S_FIN        = 3'd4;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    logic [2:0]  state;
    logic [31:0] acc;
    logic        neg;
    logic        seen_digit;
    logic [3:0]  idx;       // byte index within the string request
    logic [3:0]  last_idx;  // 4N-1 for an N-word string request

    logic        req_ok;
    logic        take;
    logic        is_digit;
    logic        is_sep;
    logic        str_end;
    logic [7:0]  digit;
    logic [31:0] acc_next;
    logic [31:0] acc_signed;
    logic [4:0]  byte_lo;

    // Decode the request, the handshake and the byte class.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_ok     = 1'b0;
        digit      = in_data - CH_ZERO;
        is_digit   = (in_data >= CH_ZERO) && (in_data <= CH_NINE);
        is_sep     = (in_data == TERM) || (in_data == CH_SPACE);
        str_end    = (in_data == TERM) || (in_data == 8'h00);
        acc_next   = (acc * 32'd10) + {24'd0, digit};
        acc_signed = neg ? (~acc + 32'd1) : acc;
        // Byte k of a word lands at bits [31-8*(k%4) -: 8]; ~k[1:0] is 3-k%4.
        byte_lo    = {~idx[1:0], 3'b000};
        take       = in_valid && in_ready;
        if (start && (ID == 32'(SYSCALL_ID)) &&
            ((rs == 32'd9) || (rs == 32'd11) || ((rs >= 32'd12) && (rs <= 32'd15))))
            req_ok = 1'b1;
    end

    assign in_ready = (state == S_INT_SIGN) || (state == S_INT_DIGITS) || (state == S_STR);
    assign busy     = in_ready;
    assign done     = (state == S_FIN);

    // Request FSM, integer accumulator, string packer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= 32'd0;
            neg        <= 1'b0;
            seen_digit <= 1'b0;
            idx        <= 4'd0;
            last_idx   <= 4'd0;
            rd0        <= 32'd0;
            rd1        <= 32'd0;
            rd2        <= 32'd0;
            rd3        <= 32'd0;
            err        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its peers.
            case (state)
                S_IDLE: begin
                    if (req_ok) begin
                        rd0        <= 32'd0;
                        rd1        <= 32'd0;
                        rd2        <= 32'd0;
                        rd3        <= 32'd0;
                        err        <= 1'b0;
                        acc        <= 32'd0;
                        neg        <= 1'b0;
                        seen_digit <= 1'b0;
                        idx        <= 4'd0;
                        last_idx   <= {rs[1:0], 2'b11};
                        if (rs == 32'd9)
                            state <= S_INT_SIGN;
                        else if (rs == 32'd11)
                            state <= S_INT_DIGITS;
                        else
                            state <= S_STR;
                    end
                end

                S_INT_SIGN, S_INT_DIGITS: begin
                    if (take) begin
                        if ((state == S_INT_SIGN) && (in_data == CH_MINUS)) begin
                            neg   <= 1'b1;
                            state <= S_INT_DIGITS;
                        end else if (is_digit) begin
                            acc        <= acc_next;
                            seen_digit <= 1'b1;
                            state      <= S_INT_DIGITS;
                        end else begin
                            state <= S_FIN;
                            if (is_sep && seen_digit) begin
                                rd0 <= acc_signed;
                                err <= 1'b0;
                            end else begin
                                rd0 <= 32'd0;
                                err <= 1'b1;
                            end
                        end
                    end
                end

                S_STR: begin
                    if (take) begin
                        if (str_end) begin
                            state <= S_FIN;
                        end else begin
                            case (idx[3:2])
                                2'd0:    rd0[byte_lo +: 8] <= in_data;
                                2'd1:    rd1[byte_lo +: 8] <= in_data;
                                2'd2:    rd2[byte_lo +: 8] <= in_data;
                                default: rd3[byte_lo +: 8] <= in_data;
                            endcase
                            if (idx == last_idx)
                                state <= S_FIN;
                            else
                                idx <= idx + 4'd1;
                        end
                    end
                end

                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_reader.sv
// Self-checking bench for syscall_reader: a table of directed requests plus
// hand-written sequences for stalls, ignored starts and reset mid-read.
module tb_syscall_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] ID;
    logic [31:0] rs;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        busy, done, err;

    syscall_reader #(.SYSCALL_ID(26), .TERM(8'h0A)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ID       (ID),
        .rs       (rs),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rd0      (rd0),
        .rd1      (rd1),
        .rd2      (rd2),
        .rd3      (rd3),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;

    // Inputs change 1 time unit after posedge, so the negedge view of
    // in_valid/in_ready equals what the next posedge samples.
    always @(negedge clk) begin
        if (in_valid && in_ready) hs_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] id_v, input logic [31:0] rs_v);
        @(posedge clk); #1;
        start = 1'b1; ID = id_v; rs = rs_v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and wait (bounded) for its handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check("handshake", 32'(ok), 32'd1);
    endtask

    // Called right after the final handshake: done must be up this cycle only.
    task automatic finish_req(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input logic e_err);
        @(negedge clk);
        check({name, ".done"},     32'(done),     32'd1);
        check({name, ".busy"},     32'(busy),     32'd0);
        check({name, ".in_ready"}, 32'(in_ready), 32'd0);
        check({name, ".rd0"}, rd0, e0);
        check({name, ".rd1"}, rd1, e1);
        check({name, ".rd2"}, rd2, e2);
        check({name, ".rd3"}, rd3, e3);
        check({name, ".err"}, 32'(err), 32'(e_err));
        @(negedge clk);
        check({name, ".done_drop"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [31:0] rs;
        int          nbytes;   // bytes the request must consume
        logic [31:0] rd0, rd1, rd2, rd3;
        logic        err;
    } vec_t;

    localparam int NV = 12;

    initial begin
        vec_t        vecs [NV];
        string       strs [NV];
        string       s;
        string       nm;
        int          hs0;
        int          d0;
        logic [31:0] last_rd0;

        vecs[0]  = '{32'd9,  6,  32'hFFFFFC17, 32'd0, 32'd0, 32'd0, 1'b0}; strs[0]  = "-1001\n";
        vecs[1]  = '{32'd11, 11, 32'd1,        32'd0, 32'd0, 32'd0, 1'b0}; strs[1]  = "4294967297\n";
        vecs[2]  = '{32'd11, 1,  32'd0,        32'd0, 32'd0, 32'd0, 1'b1}; strs[2]  = "-5\n";
        vecs[3]  = '{32'd13, 7,  32'h41424344, 32'h45460000, 32'd0, 32'd0, 1'b0}; strs[3] = "ABCDEF\n";
        vecs[4]  = '{32'd9,  4,  32'd123,      32'd0, 32'd0, 32'd0, 1'b0}; strs[4]  = "123 ";
        vecs[5]  = '{32'd9,  1,  32'd0,        32'd0, 32'd0, 32'd0, 1'b1}; strs[5]  = "\n";
        vecs[6]  = '{32'd9,  2,  32'd0,        32'd0, 32'd0, 32'd0, 1'b1}; strs[6]  = "-\n";
        vecs[7]  = '{32'd12, 4,  32'h5758595A, 32'd0, 32'd0, 32'd0, 1'b0}; strs[7]  = "WXYZ";
        vecs[8]  = '{32'd11, 3,  32'd0,        32'd0, 32'd0, 32'd0, 1'b1}; strs[8]  = "12a";
        vecs[9]  = '{32'd14, 3,  32'h48490000, 32'd0, 32'd0, 32'd0, 1'b0}; strs[9]  = "HI\n";
        vecs[10] = '{32'd9,  12, 32'h80000000, 32'd0, 32'd0, 32'd0, 1'b0}; strs[10] = "-2147483648\n";
        vecs[11] = '{32'd11, 2,  32'd0,        32'd0, 32'd0, 32'd0, 1'b0}; strs[11] = "0\n";

        reset = 1'b1; start = 1'b0; ID = 32'd0; rs = 32'd0;
        in_data = 8'h00; in_valid = 1'b0;
        #1;
        check("reset.rd0", rd0, 32'd0);
        check("reset.rd3", rd3, 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven requests.
        for (int i = 0; i < NV; i++) begin
            s   = strs[i];
            nm  = $sformatf("vec%0d", i);
            hs0 = hs_cnt;
            start_req(32'd26, vecs[i].rs);
            check({nm, ".busy_start"}, 32'(busy), 32'd1);
            for (int j = 0; j < vecs[i].nbytes; j++)
                send_byte(s[j], 0);
            finish_req(nm, vecs[i].rd0, vecs[i].rd1, vecs[i].rd2, vecs[i].rd3, vecs[i].err);
            check({nm, ".consumed"}, 32'(hs_cnt - hs0), 32'(vecs[i].nbytes));
        end

        // Ignored requests: wrong ID, then unsupported service code.
        last_rd0 = vecs[NV-1].rd0;
        d0 = done_cnt;
        start_req(32'd14, 32'd9);
        check("ign_id.busy", 32'(busy), 32'd0);
        check("ign_id.in_ready", 32'(in_ready), 32'd0);
        start_req(32'd26, 32'd3);
        repeat (2) @(negedge clk);
        check("ign_rs.busy", 32'(busy), 32'd0);
        check("ign_rs.in_ready", 32'(in_ready), 32'd0);
        check("ign.done_count", 32'(done_cnt - d0), 32'd0);
        check("ign.rd0", rd0, last_rd0);

        // 16-char string with random stalls and a start injected mid-read.
        s   = "ABCDEFGHIJKLMNOP";
        hs0 = hs_cnt;
        start_req(32'd26, 32'd15);
        for (int j = 0; j < 16; j++) begin
            send_byte(s[j], int'($urandom_range(0, 3)));
            if (j == 4) begin
                start = 1'b1; ID = 32'd26; rs = 32'd9;
                @(posedge clk); #1;
                start = 1'b0;
                check("str16.busy_after_start", 32'(busy), 32'd1);
            end
        end
        finish_req("str16", 32'h41424344, 32'h45464748, 32'h494A4B4C, 32'h4D4E4F50, 1'b0);
        in_data = 8'h51; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("str16.consumed", 32'(hs_cnt - hs0), 32'd16);
        check("str16.rd3_hold", rd3, 32'h4D4E4F50);

        // Reset in the middle of a 12-char read.
        s = "ABCDE";
        start_req(32'd26, 32'd14);
        for (int j = 0; j < 5; j++)
            send_byte(s[j], 0);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid.rd0", rd0, 32'd0);
        check("rst_mid.rd1", rd1, 32'd0);
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.no_done", 32'(done_cnt - d0), 32'd0);
        s = "WXYZ";
        start_req(32'd26, 32'd12);
        for (int j = 0; j < 4; j++)
            send_byte(s[j], 0);
        finish_req("after_rst", 32'h5758595A, 32'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syscall_reader.md
Name: syscall_reader

Overview:
- Input-side syscall unit: services the read syscalls by consuming a byte stream (console/keyboard) over a valid/ready handshake.
- Assembles the bytes into a signed integer, an unsigned integer, or a packed string of 4/8/12/16 chars in up to four result words.
- Sits beside the syscall display path in system_top and is triggered by a decoded instruction ID plus a service code in rs.

Parameters:
- SYSCALL_ID, 26, decoded instruction ID that identifies a syscall.
- TERM, 8'h0A, line terminator byte ('\n').

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- ID  input  32  decoded instruction ID.
- rs  input  32  service code: 9 = read signed int, 11 = read unsigned int, 12/13/14/15 = read 4/8/12/16-char string.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  reader accepts a byte this cycle.
- rd0, rd1, rd2, rd3  output  32 each  result words; an integer result uses rd0 only.
- busy  output  1  a request is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  parse error flag, valid with done.

Behaviour:
- Reset (async): state IDLE; rd0..rd3 = 0; busy = done = err = in_ready = 0; accumulator and counters cleared. Reset mid-request aborts it with no done pulse.
- FSM states: IDLE, INT_SIGN, INT_DIGITS, STR, FIN.
- IDLE: start && ID==SYSCALL_ID && rs in {9,11,12..15}:
  - clear rd0..rd3 and err;
  - set busy;
  - go to INT_SIGN (rs = 9), INT_DIGITS (rs = 11), or STR (rs 12..15, word count N = rs-11).
  - Any other start is ignored: no busy, no done, outputs unchanged.
- start while busy is ignored.
- in_ready = 1 exactly in INT_SIGN, INT_DIGITS and STR. A byte is consumed only on in_valid && in_ready; no byte is consumed in IDLE or FIN.
- INT_SIGN: '-' (0x2D) sets neg and moves to INT_DIGITS. Any other byte is handled as in INT_DIGITS in the same cycle.
- INT_DIGITS:
  - '0'..'9': acc = acc*10 + digit, 32-bit truncation (wraps mod 2^32); set seen_digit.
  - TERM or ' ' (0x20): if seen_digit, go to FIN with err = 0; else go to FIN with err = 1.
  - Any other byte (including '-' for rs = 11): go to FIN with err = 1.
- INT result in FIN:
  - err = 0: rd0 = neg ? (~acc + 1) : acc.
  - err = 1: rd0 = 0.
- STR: byte index k counts 0..4N-1. Byte k goes to word k/4 (rd0 first) at bits [31-8*(k%4) -: 8], so "ABCD" packs as 32'h41424344.
  - TERM or 0x00: ends the request early and is not stored; remaining bytes stay 0.
  - After byte 4N-1 is stored: go to FIN. No trailing terminator is consumed.
  - err is always 0.
- FIN: done = 1 for one cycle; busy drops in the same cycle; next state IDLE.
- Latency: done is asserted the cycle after the final byte handshake.
- rd0..rd3 and err hold until the next accepted start or reset.
- in_valid stalls: the FSM waits indefinitely with in_ready held high.

Test Plan:
- Signed int: rs=9, stream "-1001\n" → done after 6th handshake; rd0 = 32'hFFFFFC17 (-1001); err = 0; rd1..rd3 = 0.
- Unsigned wrap: rs=11, stream "4294967297\n" → rd0 = 1; err = 0. Then stream "-5\n" on rs=11 → err = 1, rd0 = 0, and the request ends after '-'.
- String 16 chars: rs=15, stream "ABCDEFGHIJKLMNOP" with random in_valid gaps → rd0 = "ABCD", rd1 = "EFGH", rd2 = "IJKL", rd3 = "MNOP"; exactly 16 bytes consumed; in_ready low after FIN.
- Early terminator: rs=13, stream "ABCDEF\n" → rd0 = 32'h41424344, rd1 = 32'h45460000; done one cycle after '\n'.
- Ignored requests: start with ID=14, rs=9, and start with ID=26, rs=3 → busy, done and in_ready stay 0; outputs unchanged. start during a busy string read → no effect on that read.
- Reset mid-read: rs=14, assert reset after 5 bytes → outputs immediately 0; no done pulse; a new rs=12 "WXYZ" read returns rd0 = "WXYZ".
